op_sequencer: RTL and testbench
===============================

// Module: op_sequencer
// PURPOSE
//   Queues logic-processor operations (function F, routing R) and sequences the
//   8-bit register/compute/router datapath through one full shift pass per op.
//   Sits between the synchronized switch/button inputs and register_unit,
//   replacing direct Execute-driven control with a command FIFO and FSM.
//   LoadA/LoadB requests are forwarded only while the datapath is idle.
// PARAMETERS
//   WIDTH  8  register width; Shift_En is asserted for exactly WIDTH cycles per op
//   DEPTH  4  command FIFO entries; power of 2, >= 2
// PORTS
//   Clk         in   1               system clock, all state on rising edge
//   Reset       in   1               asynchronous, active-high; clears all state
//   Cmd_Valid   in   1               command present on Cmd_F/Cmd_R
//   Cmd_F       in   3               function select for queued op
//   Cmd_R       in   2               routing select for queued op
//   Cmd_Ready   out  1               FIFO can accept; push = Cmd_Valid & Cmd_Ready
//   LoadA       in   1               load-A request (synchronized, active-high)
//   LoadB       in   1               load-B request (synchronized, active-high)
//   Ld_A        out  1               load strobe to register A
//   Ld_B        out  1               load strobe to register B
//   Shift_En    out  1               shift enable to register_unit
//   F_Out       out  3               function select to compute unit
//   R_Out       out  2               routing select to router
//   Busy        out  1               FSM not in IDLE
//   Done        out  1               one-cycle pulse at op completion
//   Fifo_Count  out  $clog2(DEPTH+1) entries currently queued
// BEHAVIOUR
//   Reset: FIFO emptied, state IDLE, shift counter 0; all outputs 0 except Cmd_Ready=1.
//   FIFO: circular, pointers wrap mod DEPTH. Cmd_Ready = (Fifo_Count != DEPTH).
//     Full FIFO: Cmd_Ready=0 even if a pop occurs that cycle (no pass-through).
//     Empty + push: entry is visible to FSM next cycle (no bypass).
//     Simultaneous push and pop: Fifo_Count unchanged.
//   FSM states IDLE -> FETCH -> SHIFT -> DONE -> IDLE.
//     IDLE : Ld_A=LoadA, Ld_B=LoadB (combinational, both may be high together).
//            LoadA|LoadB high: stay IDLE, no pop (loads have priority).
//            else FIFO non-empty: pop head, go FETCH.
//     FETCH: F_Out/R_Out registered from popped entry; 1 cycle; go SHIFT.
//     SHIFT: Shift_En=1; counter 0..WIDTH-1; at WIDTH-1 go DONE.
//     DONE : Done=1 for 1 cycle; go IDLE.
//   Latency: pop-decision edge to Done = 1 (FETCH) + WIDTH (SHIFT) + 1 cycles.
//   Back-to-back ops: at least 1 IDLE cycle between DONE and next FETCH.
//   F_Out/R_Out hold last op's value until next FETCH; stable during all of SHIFT.
//   Outside IDLE: Ld_A=Ld_B=0; LoadA/LoadB ignored, not remembered.
//   Reset mid-op: Shift_En, Done, Busy drop asynchronously; op discarded.
//   Busy = (state != IDLE). Shift_En/Done/Ld_* never assert under Reset.
// CONFIGURATION
//   OP_COUNT_EN defined: adds output Op_Count [7:0], reset 0, +1 on each DONE
//     cycle, wraps 255 -> 0.
//   OP_COUNT_EN undefined: Op_Count port and counter absent; all else identical.
// TESTING
//   1. Assert Reset mid-run then release -> all outputs 0, Cmd_Ready=1, Fifo_Count=0.
//   2. Idle, push F=3'b010 R=2'b01 -> FETCH next cycle, F_Out=3'b010, R_Out=2'b01,
//      Shift_En high exactly 8 consecutive cycles, Done 1 cycle after, Busy 10 cycles.
//   3. Hold LoadA=1, push 5 cmds back-to-back (DEPTH=4) -> 4 accepted, Cmd_Ready=0,
//      Fifo_Count=4; release LoadA -> pop, Cmd_Ready=1 next cycle, 5th accepted.
//   4. LoadB pulse during SHIFT -> Ld_B stays 0; LoadA=LoadB=1 in IDLE -> Ld_A=Ld_B=1
//      same cycle, no pop despite non-empty FIFO.
//   5. Reset at SHIFT cycle 3 with 2 queued -> Shift_En=0 immediately, Fifo_Count=0,
//      no Done pulse.
//   6. OP_COUNT_EN: run 3 ops -> Op_Count=3; run 256 ops from reset -> Op_Count=0.

Source files
------------

// File: rtl/op_sequencer.sv
// op_sequencer: command FIFO plus a sequencing FSM for the 8-bit logic-processor
// datapath. Each queued op (function F, routing R) is fetched, then the register
// unit is shifted for exactly WIDTH cycles, then a one-cycle Done pulse is issued.
// Load requests are forwarded to the registers only while the sequencer is idle.
// Optional feature macro: OP_COUNT_EN adds the 8-bit completed-op counter Op_Count.
module op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Cmd_Valid,
    input  logic [2:0]                 Cmd_F,
    input  logic [1:0]                 Cmd_R,
    output logic                       Cmd_Ready,
    input  logic                       LoadA,
    input  logic                       LoadB,
    output logic                       Ld_A,
    output logic                       Ld_B,
    output logic                       Shift_En,
    output logic [2:0]                 F_Out,
    output logic [1:0]                 R_Out,
    output logic                       Busy,
    output logic                       Done,
    output logic [$clog2(DEPTH+1)-1:0] Fifo_Count
`ifdef OP_COUNT_EN
    ,
    output logic [7:0]                 Op_Count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SH_ONE   = SW'(1);
    localparam logic [SW-1:0] SH_LAST  = SW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // Command storage: {F, R} per entry, circular with power-of-2 wrap
    logic [4:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    state_t        state_q;
    logic [SW-1:0] sh_cnt_q;
    logic [2:0]    f_q;
    logic [1:0]    r_q;
    logic          shift_en_q;
    logic          done_q;
    logic          busy_q;

    logic          push_s;
    logic          pop_s;
    logic          idle_s;

    // Full FIFO refuses pushes even when a pop happens the same cycle
    assign Cmd_Ready  = (count_q != CNT_FULL);
    assign push_s     = Cmd_Valid & Cmd_Ready;
    assign idle_s     = (state_q == S_IDLE);
    // Loads win over fetching a new op; an empty FIFO never pops
    assign pop_s      = idle_s & ~LoadA & ~LoadB & (count_q != {CW{1'b0}});

    // Load strobes pass straight through only while idle and out of reset
    assign Ld_A       = LoadA & idle_s & ~Reset;
    assign Ld_B       = LoadB & idle_s & ~Reset;

    assign Shift_En   = shift_en_q;
    assign Done       = done_q;
    assign Busy       = busy_q;
    assign F_Out      = f_q;
    assign R_Out      = r_q;
    assign Fifo_Count = count_q;

    // Occupancy next-state: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers; reset discards every queued command
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 5'b00000;
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {Cmd_F, Cmd_R};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Sequencer FSM with registered strobes: IDLE -> FETCH -> SHIFT x WIDTH -> DONE
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            sh_cnt_q   <= {SW{1'b0}};
            f_q        <= 3'b000;
            r_q        <= 2'b00;
            shift_en_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        state_q <= S_FETCH;
                        f_q     <= mem_q[rd_ptr_q][4:2];
                        r_q     <= mem_q[rd_ptr_q][1:0];
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    state_q    <= S_SHIFT;
                    sh_cnt_q   <= {SW{1'b0}};
                    shift_en_q <= 1'b1;
                end
                S_SHIFT: begin
                    if (sh_cnt_q == SH_LAST) begin
                        state_q    <= S_DONE;
                        shift_en_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        sh_cnt_q <= sh_cnt_q + SH_ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    sh_cnt_q   <= {SW{1'b0}};
                    shift_en_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef OP_COUNT_EN
    logic [7:0] op_cnt_q;

    assign Op_Count = op_cnt_q;

    // Completed-op counter, bumped once per DONE cycle and wrapping at 256
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_cnt_q <= 8'd0;
        end else if (done_q) begin
            op_cnt_q <= op_cnt_q + 8'd1;
        end else begin
            op_cnt_q <= op_cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: a queue-and-age reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_op_sequencer;

    localparam int W = 8;
    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Cmd_Valid = 1'b0;
    logic [2:0] Cmd_F = 3'b000;
    logic [1:0] Cmd_R = 2'b00;
    logic       LoadA = 1'b0;
    logic       LoadB = 1'b0;
    logic       Cmd_Ready, Ld_A, Ld_B, Shift_En, Busy, Done;
    logic [2:0] F_Out;
    logic [1:0] R_Out;
    logic [2:0] Fifo_Count;
`ifdef OP_COUNT_EN
    logic [7:0] Op_Count;
`endif

    op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .Clk(Clk), .Reset(Reset), .Cmd_Valid(Cmd_Valid), .Cmd_F(Cmd_F), .Cmd_R(Cmd_R),
        .Cmd_Ready(Cmd_Ready), .LoadA(LoadA), .LoadB(LoadB), .Ld_A(Ld_A), .Ld_B(Ld_B),
        .Shift_En(Shift_En), .F_Out(F_Out), .R_Out(R_Out), .Busy(Busy), .Done(Done),
        .Fifo_Count(Fifo_Count)
`ifdef OP_COUNT_EN
        , .Op_Count(Op_Count)
`endif
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queued commands and the age of the running op
    // (0 = idle, 1 = fetch, 2..W+1 = shift cycles, W+2 = done cycle)
    logic [4:0] m_q[$];
    int         age = 0;
    logic [2:0] m_f = 3'b000;
    logic [1:0] m_r = 2'b00;
    int         m_ops = 0;
    bit         mp_push, mp_pop;

    int busy_n, sh_n, done_n, sh_run, sh_max, first_busy, done_at, found;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic wait_idle(input string nm);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            if (!Busy && Fifo_Count == 3'd0) begin
                found = 1;
                break;
            end
        end
        chk(nm, found, 1);
    endtask

    // Model update on every rising edge from the inputs the DUT also sees
    initial begin
        forever begin
            @(posedge Clk);
            if (Reset) begin
                m_q.delete();
                age = 0; m_f = 3'b000; m_r = 2'b00; m_ops = 0;
            end else begin
                mp_push = Cmd_Valid && (m_q.size() < D);
                mp_pop  = (age == 0) && !LoadA && !LoadB && (m_q.size() > 0);
                if (age == W + 2) m_ops = (m_ops + 1) % 256;
                if (mp_pop) begin
                    {m_f, m_r} = m_q.pop_front();
                    age = 1;
                end else if (age == W + 2) begin
                    age = 0;
                end else if (age != 0) begin
                    age = age + 1;
                end
                if (mp_push) m_q.push_back({Cmd_F, Cmd_R});
            end
        end
    end

    // Cycle compare on the falling edge against the model (reset values under Reset)
    initial begin
        forever begin
            @(negedge Clk);
            chk("cmd_ready",  int'(Cmd_Ready),  Reset ? 1 : int'(m_q.size() != D));
            chk("fifo_count", int'(Fifo_Count), Reset ? 0 : m_q.size());
            chk("busy",       int'(Busy),       int'(!Reset && age != 0));
            chk("shift_en",   int'(Shift_En),   int'(!Reset && age >= 2 && age <= W + 1));
            chk("done",       int'(Done),       int'(!Reset && age == W + 2));
            chk("ld_a",       int'(Ld_A),       int'(!Reset && age == 0 && LoadA));
            chk("ld_b",       int'(Ld_B),       int'(!Reset && age == 0 && LoadB));
            chk("f_out",      int'(F_Out),      Reset ? 0 : int'(m_f));
            chk("r_out",      int'(R_Out),      Reset ? 0 : int'(m_r));
`ifdef OP_COUNT_EN
            chk("op_count",   int'(Op_Count),   Reset ? 0 : m_ops);
`endif
        end
    end

    initial begin
        #150000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (3) tick();
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_ready", int'(Cmd_Ready), 1);
        chk("rst_count", int'(Fifo_Count), 0);
        chk("rst_busy",  int'(Busy), 0);

        // Single op: fetch, 8 shift cycles, done
        tick();
        Cmd_Valid = 1'b1; Cmd_F = 3'b010; Cmd_R = 2'b01;
        tick();
        Cmd_Valid = 1'b0;
        busy_n = 0; sh_n = 0; done_n = 0; sh_run = 0; sh_max = 0; first_busy = -1; done_at = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            if (Busy) begin
                busy_n++;
                if (first_busy < 0) begin
                    first_busy = i;
                    chk("t2_f_fetch", int'(F_Out), 2);
                    chk("t2_r_fetch", int'(R_Out), 1);
                end
            end
            if (Shift_En) begin
                sh_n++; sh_run++;
                if (sh_run > sh_max) sh_max = sh_run;
            end else begin
                sh_run = 0;
            end
            if (Done) begin
                done_n++;
                done_at = i;
            end
        end
        chk("t2_fetch_lat", first_busy, 1);
        chk("t2_busy_cyc",  busy_n, 10);
        chk("t2_shift_cyc", sh_n, 8);
        chk("t2_shift_run", sh_max, 8);
        chk("t2_done_cyc",  done_n, 1);
        chk("t2_done_at",   done_at, 10);

        // Loads hold off popping; fill to full, fifth push refused until a pop
        tick();
        LoadA = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Cmd_Valid = 1'b1; Cmd_F = 3'(i + 1); Cmd_R = 2'(i);
            tick();
        end
        @(negedge Clk);
        chk("t3_full_count", int'(Fifo_Count), 4);
        chk("t3_full_ready", int'(Cmd_Ready), 0);
        chk("t3_full_lda",   int'(Ld_A), 1);
        tick();
        LoadA = 1'b0;
        @(negedge Clk);
        chk("t3_pop_count", int'(Fifo_Count), 4);
        tick();
        @(negedge Clk);
        chk("t3_pop_ready", int'(Cmd_Ready), 1);
        chk("t3_pop_cnt3",  int'(Fifo_Count), 3);
        tick();
        Cmd_Valid = 1'b0;
        @(negedge Clk);
        chk("t3_fifth_in", int'(Fifo_Count), 4);
        wait_idle("t3_drain_timeout");
        chk("t3_last_f", int'(F_Out), 5);
        chk("t3_last_r", int'(R_Out), 0);

        // LoadB ignored while shifting; both loads in idle block the pop
        tick();
        Cmd_Valid = 1'b1; Cmd_F = 3'b111; Cmd_R = 2'b11;
        tick();
        Cmd_Valid = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge Clk);
            if (Shift_En) found = 1;
        end
        chk("t4_shift_seen", found, 1);
        tick();
        LoadB = 1'b1; Cmd_Valid = 1'b1; Cmd_F = 3'b001; Cmd_R = 2'b10;
        @(negedge Clk);
        chk("t4_ldb_in_shift", int'(Ld_B), 0);
        tick();
        LoadB = 1'b0; Cmd_Valid = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge Clk);
            if (Done) found = 1;
        end
        chk("t4_done_seen", found, 1);
        tick();
        LoadA = 1'b1; LoadB = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge Clk);
            chk("t4_both_lda", int'(Ld_A), 1);
            chk("t4_both_ldb", int'(Ld_B), 1);
            chk("t4_no_pop",   int'(Fifo_Count), 1);
            chk("t4_idle",     int'(Busy), 0);
            tick();
        end
        LoadA = 1'b0; LoadB = 1'b0;
        wait_idle("t4_drain_timeout");
        chk("t4_last_f", int'(F_Out), 1);
        chk("t4_last_r", int'(R_Out), 2);

        // Reset at shift cycle 3 with two ops queued
        tick();
        Cmd_Valid = 1'b1; Cmd_F = 3'b011; Cmd_R = 2'b00;
        tick();
        Cmd_F = 3'b100;
        tick();
        Cmd_F = 3'b101;
        tick();
        Cmd_Valid = 1'b0;
        @(negedge Clk);
        chk("t5_shift0", int'(Shift_En), 1);
        chk("t5_queued", int'(Fifo_Count), 2);
        repeat (3) tick();
        #1;
        Reset = 1'b1;
        #1;
        chk("t5_rst_shift", int'(Shift_En), 0);
        chk("t5_rst_busy",  int'(Busy), 0);
        chk("t5_rst_done",  int'(Done), 0);
        chk("t5_rst_count", int'(Fifo_Count), 0);
        chk("t5_rst_ready", int'(Cmd_Ready), 1);
        tick();
        tick();
        Reset = 1'b0;
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Done) done_n++;
            if (Busy) busy_n++;
        end
        chk("t5_no_done", done_n, 0);
        chk("t5_no_busy", busy_n, 0);

`ifdef OP_COUNT_EN
        // Op counter: three ops, then 256 ops from reset wrap to zero
        tick();
        Cmd_Valid = 1'b1; Cmd_F = 3'b110; Cmd_R = 2'b01;
        repeat (3) tick();
        Cmd_Valid = 1'b0;
        wait_idle("t6_three_timeout");
        chk("t6_three", int'(Op_Count), 3);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Cmd_Valid = 1'b1; Cmd_F = 3'b000; Cmd_R = 2'b00;
        done_n = 0;
        for (int c = 0; c < 4000 && done_n < 256; c++) begin
            @(negedge Clk);
            if (Done) done_n++;
        end
        chk("t6_256_done", done_n, 256);
        tick();
        Cmd_Valid = 1'b0;
        @(negedge Clk);
        chk("t6_wrap", int'(Op_Count), 0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
